// File: rtl/rec_pkg.sv
// Shared types for the record link: the packed record, the receiver FSM states
// and the default frame-start byte.
package rec_pkg;

   typedef struct packed {
      byte        a;
      byte        b;
      logic [7:0] t;
   } rec_t;

   typedef enum logic [2:0] {HUNT, FA, FB, FT, CK} st_t;

   localparam logic [7:0] DEF_SYNC = 8'hA5;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/rec_deser.sv
// Byte-stream receiver: hunts for SYNC, collects a/b/t, verifies the XOR checksum
// and presents the rebuilt record on a valid/ready output register.
module rec_deser
   import rec_pkg::*;
#(
   parameter logic [7:0]  SYNC  = DEF_SYNC,
   parameter int unsigned CNT_W = 16,
   parameter int unsigned ERR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output rec_pkg::rec_t     out_rec,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              err,
   output logic [CNT_W-1:0]  good_cnt,
   output logic [ERR_W-1:0]  err_cnt
);

   st_t        state_q, state_d;
   rec_t       shadow_q, shadow_d;
   logic [7:0] chk_q, chk_d;
   rec_t       out_rec_q;
   logic       out_valid_q;
   logic       err_q;
   logic [CNT_W-1:0] good_cnt_q;
   logic       accept;
   logic       load;
   logic       bad;

   // Only the checksum byte waits for the output slot; frame bytes always flow.
   assign in_ready = (state_q != CK) || !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      chk_d    = chk_q;
      load     = 1'b0;
      bad      = 1'b0;
      case (state_q)
         HUNT: begin
            if (accept && (in_data == SYNC)) begin
               state_d = FA;
               chk_d   = SYNC;
            end
         end
         FA: begin
            if (accept) begin
               shadow_d.a = in_data;
               chk_d      = chk_q ^ in_data;
               state_d    = FB;
            end
         end
         FB: begin
            if (accept) begin
               shadow_d.b = in_data;
               chk_d      = chk_q ^ in_data;
               state_d    = FT;
            end
         end
         FT: begin
            if (accept) begin
               shadow_d.t = in_data;
               chk_d      = chk_q ^ in_data;
               state_d    = CK;
            end
         end
         CK: begin
            if (accept) begin
               if (in_data == chk_q) begin
                  load = 1'b1;
               end else begin
                  bad      = 1'b1;
                  shadow_d = '0;
               end
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         shadow_q    <= '0;
         chk_q       <= '0;
         out_rec_q   <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         good_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         chk_q       <= chk_d;
         // A load in the pop cycle keeps valid high, giving back-to-back records.
         out_valid_q <= load || (out_valid_q && !out_ready);
         err_q       <= bad;
         if (load) begin
            out_rec_q  <= shadow_q;
            good_cnt_q <= good_cnt_q + CNT_W'(1);
         end
      end
   end

   sat_cnt #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (bad),
      .cnt (err_cnt)
   );

   assign out_rec   = out_rec_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;
   assign good_cnt  = good_cnt_q;

endmodule

// File: tb/tb_rec_deser.sv
// Directed bench for rec_deser: good/bad frames, garbage, backpressure, reset, saturation.
module tb_rec_deser;
   import rec_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] out_rec;
   logic        out_valid;
   logic        out_ready;
   logic        err;
   logic [15:0] good_cnt;
   logic [7:0]  err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   rec_deser #(
      .SYNC  (8'hA5),
      .CNT_W (16),
      .ERR_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_rec   (out_rec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err),
      .good_cnt  (good_cnt),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte is accepted.
   task automatic send(input logic [7:0] b);
      int n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_eq("send_timeout", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] t,
                             input logic [7:0] c);
      send(8'hA5);
      send(a);
      send(b);
      send(t);
      send(c);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_rec", out_rec, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_good_cnt", good_cnt, 0);
      check_eq("rst_err_cnt", err_cnt, 0);
      check_eq("rst_in_ready", in_ready, 1);

      // Good frame
      send_frame(8'hAA, 8'h55, 8'h01, 8'h5B);
      check_eq("t1_out_valid", out_valid, 1);
      check_eq("t1_out_rec", out_rec, 24'hAA5501);
      check_eq("t1_good_cnt", good_cnt, 1);
      check_eq("t1_err", err, 0);
      @(negedge clk);
      check_eq("t1_popped", out_valid, 0);

      // Bad checksum, then recovery
      send_frame(8'hAA, 8'h55, 8'h01, 8'h5C);
      check_eq("t2_err", err, 1);
      check_eq("t2_err_cnt", err_cnt, 1);
      check_eq("t2_out_valid", out_valid, 0);
      @(negedge clk);
      check_eq("t2_err_pulse", err, 0);
      send_frame(8'h01, 8'h02, 8'h03, 8'hA5);
      check_eq("t2_out_valid2", out_valid, 1);
      check_eq("t2_out_rec2", out_rec, 24'h010203);
      check_eq("t2_good_cnt", good_cnt, 2);

      // Leading garbage
      send(8'h00);
      send(8'hFF);
      send(8'h13);
      check_eq("t3_garbage_valid", out_valid, 0);
      check_eq("t3_garbage_err", err, 0);
      send_frame(8'h10, 8'h20, 8'h30, 8'hA5);
      check_eq("t3_out_rec", out_rec, 24'h102030);
      check_eq("t3_good_cnt", good_cnt, 3);
      check_eq("t3_err_cnt", err_cnt, 1);
      @(negedge clk);
      check_eq("t3_popped", out_valid, 0);

      // Backpressure: second record waits for the slot, then loads with no bubble
      out_ready = 1'b0;
      send_frame(8'h11, 8'h22, 8'h44, 8'hD2);
      check_eq("t4_first_valid", out_valid, 1);
      check_eq("t4_first_rec", out_rec, 24'h112244);
      send(8'hA5);
      send(8'h01);
      send(8'h02);
      send(8'h04);
      check_eq("t4_ck_in_ready", in_ready, 0);
      in_data  = 8'hA2;
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("t4_hold_in_ready", in_ready, 0);
      check_eq("t4_hold_rec", out_rec, 24'h112244);
      check_eq("t4_hold_valid", out_valid, 1);
      check_eq("t4_hold_good", good_cnt, 4);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check_eq("t4_second_valid", out_valid, 1);
      check_eq("t4_second_rec", out_rec, 24'h010204);
      check_eq("t4_good_cnt", good_cnt, 5);

      // Reset mid-frame with a record still pending
      send(8'hA5);
      send(8'hAA);
      check_eq("t5_pending", out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      check_eq("t5_out_valid", out_valid, 0);
      check_eq("t5_good_cnt", good_cnt, 0);
      check_eq("t5_err_cnt", err_cnt, 0);
      send(8'h55);
      send(8'h01);
      send(8'h5B);
      check_eq("t5_no_record", out_valid, 0);
      @(negedge clk);
      check_eq("t5_no_record2", out_valid, 0);
      check_eq("t5_good_after", good_cnt, 0);
      check_eq("t5_no_err", err_cnt, 0);

      // Error counter saturation
      for (int i = 0; i < 300; i++) begin
         send_frame(8'h00, 8'h00, 8'h00, 8'h00);
         if (i == 253) check_eq("t6_err_cnt_fe", err_cnt, 8'hFE);
         if (i == 254) check_eq("t6_err_cnt_ff", err_cnt, 8'hFF);
      end
      check_eq("t6_err_cnt_sat", err_cnt, 8'hFF);
      check_eq("t6_good_cnt", good_cnt, 0);
      check_eq("t6_out_valid", out_valid, 0);
      send_frame(8'h00, 8'h00, 8'h00, 8'hA5);
      check_eq("t6_good_after", good_cnt, 1);
      check_eq("t6_rec_after", out_rec, 24'h000000);
      check_eq("t6_valid_after", out_valid, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
